// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller
// Round-robin scan of DIGIT_COUNT digit positions through one shared BCD
// converter. Each digit gets a blanking gap followed by a dwell window.
// Frames are loaded through a valid/ready handshake into a pending register
// and copied to the active register only at a frame boundary (or in IDLE),
// so a displayed frame is never partially updated.
// All outputs are registered; they are computed from the next-state values
// so that they line up with the state they describe.

module seven_segment_scan_controller #(
  parameter int DIGIT_COUNT  = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [4*DIGIT_COUNT-1:0] load_digits,
  input  logic [DIGIT_COUNT-1:0]   load_digit_en,
  output logic [3:0]               bcd,
  output logic                     bcd_valid,
  output logic [DIGIT_COUNT-1:0]   digit_select,
  output logic                     frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(DIGIT_COUNT);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGIT_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t                   state_reg, state_next;
  logic [IW-1:0]            idx_reg, idx_next;
  logic [CW-1:0]            cnt_reg, cnt_next;

  logic [4*DIGIT_COUNT-1:0] active_digits_reg;
  logic [DIGIT_COUNT-1:0]   active_en_reg;
  logic [4*DIGIT_COUNT-1:0] pending_digits_reg;
  logic [DIGIT_COUNT-1:0]   pending_en_reg;
  logic                     pending_reg;

  logic                     frame_end;
  logic                     commit;
  logic                     accept;

  logic [3:0]               bcd_next;
  logic                     bcd_valid_next;
  logic [DIGIT_COUNT-1:0]   digit_select_next;
  logic                     frame_done_next;

  // Unpacked view of the active frame, one nibble per digit position
  logic [3:0]               active_digit [DIGIT_COUNT];

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT_COUNT; gi++) begin : g_unpack
      assign active_digit[gi] = active_digits_reg[4*gi +: 4];
    end
  endgenerate

  // Last dwell cycle of the last digit: frame boundary where commits happen
  assign frame_end = (state_reg == DWELL) && (idx_reg == IDX_LAST) && (cnt_reg == DWELL_LAST);
  assign commit    = pending_reg && ((state_reg == IDLE) || frame_end);
  // commit needs pending set and accept needs it clear, so they never coincide
  assign accept    = load_valid && !pending_reg;

  // Next state, digit index and cycle counter, plus the output values for that next state
  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    cnt_next          = cnt_reg;
    bcd_next          = 4'h0;
    bcd_valid_next    = 1'b0;
    digit_select_next = '0;
    frame_done_next   = 1'b0;

    if (!enable) begin
      state_next = IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = BLANK;
          idx_next   = '0;
          cnt_next   = '0;
        end
        BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = DWELL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        DWELL: begin
          if (cnt_reg == DWELL_LAST) begin
            state_next = BLANK;
            cnt_next   = '0;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end

    // Active frame only changes on an edge that leaves DWELL, so it is stable here
    if (state_next == DWELL) begin
      digit_select_next[idx_next] = 1'b1;
      bcd_next                    = active_digit[idx_next];
      bcd_valid_next              = active_en_reg[idx_next];
      frame_done_next             = (idx_next == IDX_LAST) && (cnt_next == DWELL_LAST);
    end
  end

  // Scan FSM, frame registers, handshake and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      idx_reg            <= '0;
      cnt_reg            <= '0;
      active_digits_reg  <= '0;
      active_en_reg      <= '0;
      pending_digits_reg <= '0;
      pending_en_reg     <= '0;
      pending_reg        <= 1'b0;
      load_ready         <= 1'b1;
      bcd                <= 4'h0;
      bcd_valid          <= 1'b0;
      digit_select       <= '0;
      frame_done         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      cnt_reg      <= cnt_next;
      bcd          <= bcd_next;
      bcd_valid    <= bcd_valid_next;
      digit_select <= digit_select_next;
      frame_done   <= frame_done_next;

      if (commit) begin
        active_digits_reg <= pending_digits_reg;
        active_en_reg     <= pending_en_reg;
        pending_reg       <= 1'b0;
        load_ready        <= 1'b1;
      end else if (accept) begin
        pending_digits_reg <= load_digits;
        pending_en_reg     <= load_digit_en;
        pending_reg        <= 1'b1;
        load_ready         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Testbench for seven_segment_scan_controller with DIGIT_COUNT=4,
// DWELL_CYCLES=4, BLANK_CYCLES=2. A table of per-cycle input/expected-output
// records covers idle, load-in-idle, basic scan, tear-free update,
// backpressure, per-digit blanking and disable; hand-written steps cover
// asynchronous reset mid-dwell.

module tb_seven_segment_scan_controller;

  localparam int DC = 4;
  localparam int DW = 4;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_digits = 16'h0;
  logic [3:0]  load_digit_en = 4'h0;
  logic [3:0]  bcd;
  logic        bcd_valid;
  logic [3:0]  digit_select;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  seven_segment_scan_controller #(
    .DIGIT_COUNT (DC),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_digits  (load_digits),
    .load_digit_en(load_digit_en),
    .bcd          (bcd),
    .bcd_valid    (bcd_valid),
    .digit_select (digit_select),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        lv;
    logic [15:0] ld;
    logic [3:0]  le;
    logic        rdy;
    logic [3:0]  dsel;
    logic [3:0]  bcd;
    logic        bv;
    logic        fd;
    logic        chk_bcd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(logic en, logic lv, logic [15:0] ld, logic [3:0] le,
                                  logic rdy, logic [3:0] dsel, logic [3:0] b, logic bv,
                                  logic fd, logic chk_bcd);
    vec_t v;
    v.en = en; v.lv = lv; v.ld = ld; v.le = le;
    v.rdy = rdy; v.dsel = dsel; v.bcd = b; v.bv = bv; v.fd = fd; v.chk_bcd = chk_bcd;
    tbl.push_back(v);
  endfunction

  // First n cycles of a scanned frame with enable held high and no load offered
  function automatic void add_frame(logic [15:0] d, logic [3:0] e, int n);
    int k;
    k = 0;
    for (int i = 0; i < DC; i++) begin
      for (int b = 0; b < BL; b++) begin
        if (k < n) add_vec(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0);
        k++;
      end
      for (int w = 0; w < DW; w++) begin
        if (k < n) add_vec(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 4'(1 << i), d[4*i +: 4], e[i],
                           (i == DC-1) && (w == DW-1), 1'b1);
        k++;
      end
    end
  endfunction

  function automatic void set_load(int i, logic [15:0] ld, logic [3:0] le);
    vec_t v;
    v = tbl[i];
    v.lv = 1'b1; v.ld = ld; v.le = le;
    tbl[i] = v;
  endfunction

  function automatic void set_rdy(int i, logic r);
    vec_t v;
    v = tbl[i];
    v.rdy = r;
    tbl[i] = v;
  endfunction

  task automatic check_out(string name, logic rdy, logic [3:0] dsel, logic [3:0] b,
                           logic bv, logic fd, logic chk_bcd);
    n_checks++;
    if (load_ready === rdy && digit_select === dsel && bcd_valid === bv &&
        frame_done === fd && (!chk_bcd || bcd === b)) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got ready=%b sel=%b bcd=%h valid=%b done=%b, required ready=%b sel=%b bcd=%h valid=%b done=%b",
               name, load_ready, digit_select, bcd, bcd_valid, frame_done,
               rdy, dsel, b, bv, fd);
    end
  endtask

  initial begin
    int f2, f3, f4;

    // ---------------- build the vector table ----------------
    // idle after reset
    for (int i = 0; i < 3; i++)
      add_vec(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 4'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    // load in IDLE, committed on the following cycle
    add_vec(1'b0, 1'b1, 16'h1234, 4'hF, 1'b0, 4'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 16'h0,    4'h0, 1'b1, 4'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    // frame 1: basic scan of 1234
    add_frame(16'h1234, 4'hF, 24);
    // frame 2: 1234 again; 5678 loaded during digit 1, 9ABC offered while pending
    f2 = tbl.size();
    add_frame(16'h1234, 4'hF, 24);
    set_load(f2 + 8, 16'h5678, 4'hF);
    for (int i = 8; i < 24; i++) set_rdy(f2 + i, 1'b0);
    for (int i = 14; i < 24; i++) set_load(f2 + i, 16'h9ABC, 4'b1011);
    // frame 3: 5678 shown; 9ABC accepted once ready is back
    f3 = tbl.size();
    add_frame(16'h5678, 4'hF, 24);
    set_load(f3 + 0, 16'h9ABC, 4'b1011);
    set_load(f3 + 1, 16'h9ABC, 4'b1011);
    for (int i = 1; i < 24; i++) set_rdy(f3 + i, 1'b0);
    // frame 4: 9ABC with digit 2 blanked, cut during the digit-2 dwell
    f4 = tbl.size();
    add_frame(16'h9ABC, 4'b1011, 16);
    // disable: IDLE on the next cycle
    for (int i = 0; i < 2; i++)
      add_vec(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 4'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    // re-enable: restart at digit 0 with BLANK, active frame retained
    add_frame(16'h9ABC, 4'b1011, 10);

    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    #1 check_out("reset_state", 1'b1, 4'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---------------- table-driven run ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      enable        = tbl[i].en;
      load_valid    = tbl[i].lv;
      load_digits   = tbl[i].ld;
      load_digit_en = tbl[i].le;
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].dsel, tbl[i].bcd,
                tbl[i].bv, tbl[i].fd, tbl[i].chk_bcd);
    end

    // ---------------- asynchronous reset mid-dwell ----------------
    load_valid = 1'b1; load_digits = 16'h1111; load_digit_en = 4'hF;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check_out("load_before_reset", 1'b0, 4'b0010, 4'hB, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 1'b1, 4'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    enable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check_out("idle_after_reset", 1'b1, 4'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_out("pending_discarded", 1'b1, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
